// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES word bridge: block/word geometry, the
// bridge state encoding and the word-index-to-bit-slice helper.
// Optional feature macro used by the bridge: AES_BRIDGE_TIMEOUT_EN.
package aes_pkg;

  localparam int WORD_W         = 16;
  localparam int BLOCK_WORDS    = 8;
  localparam int AES_BLOCK_W    = 128;
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } aes_state_e;

  // Blocks are MSB-first: word 0 occupies [127:112], word 7 occupies [15:0].
  // The LSB of word idx is (7 - idx) * 16, and 7 - idx == ~idx for 3 bits.
  function automatic logic [6:0] word_lsb(input logic [2:0] idx);
    return {~idx, 4'b0000};
  endfunction

endpackage

// File: rtl/aes_word_pack.sv
// aes_word_pack
// Gathers 16-bit words into a 128-bit block, MSB-first, with a word count.
// SATURATE = 1: count stops at 8 and further writes are dropped (data block).
// SATURATE = 0: count wraps 7 -> 0 and later words overwrite (key block).
// Ports:
//   clk_i, reset_n   clock, asynchronous active-low reset
//   clr_i            clear the word count (block contents are kept)
//   wr_i             write word_i at the current count position
//   word_i [15:0]    incoming word
//   block_o [127:0]  assembled block
//   cnt_o [3:0]      words written so far (0..8 or 0..7 when wrapping)
module aes_word_pack
  import aes_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  logic [WORD_W-1:0]      word_i,
  output logic [AES_BLOCK_W-1:0] block_o,
  output logic [3:0]             cnt_o
);

  logic [AES_BLOCK_W-1:0] block_q, block_d;
  logic [3:0]             cnt_q, cnt_d;

  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i && !(SATURATE && cnt_q == 4'(BLOCK_WORDS))) begin
      block_d[word_lsb(cnt_q[2:0]) +: WORD_W] = word_i;
      if (!SATURATE && cnt_q == 4'(BLOCK_WORDS - 1)) cnt_d = '0;
      else                                           cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  assign block_o = block_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/aes_word_bridge.sv
// aes_word_bridge
// Word-serial bridge between a 16-bit CPU store/load port and a 128-bit AES
// core. Collects eight key words and eight data words, launches one
// encrypt/decrypt, then returns the 128-bit result as eight 16-bit words.
// Optional feature: define AES_BRIDGE_TIMEOUT_EN for a WAIT watchdog that sets
// the sticky err_o and abandons the operation after TIMEOUT_CYCLES.
//
// Handshakes: a CPU write transfers on the edge where wr_v_i & wr_ready_o;
// a launch transfers on the edge where core_v_o & core_ready_i; a result word
// is consumed on the edge where rd_v_o & rd_yumi_i. core_done_i is a one-cycle
// pulse honoured only in WAIT.
//
// Ports:
//   clk_i, reset_n                clock, asynchronous active-low reset
//   wr_v_i, wr_key_i, wr_data_i   CPU write (key word when wr_key_i = 1)
//   mode_i                        0 encrypt / 1 decrypt, taken with data word 8
//   wr_ready_o                    write accepted
//   rd_v_o, rd_data_o, rd_yumi_i  result word stream to the CPU
//   core_v_o, core_ready_i        launch request to the core
//   core_key_o, core_data_o       key and input blocks
//   core_decrypt_o                latched mode
//   core_done_i, core_data_i      result pulse and result block
//   err_o                         sticky watchdog flag
//   dbg_state_o                   current bridge state (aes_state_e)
module aes_word_bridge
  import aes_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_n,
  input  logic                   wr_v_i,
  input  logic                   wr_key_i,
  input  logic [WORD_W-1:0]      wr_data_i,
  input  logic                   mode_i,
  output logic                   wr_ready_o,
  output logic                   rd_v_o,
  output logic [WORD_W-1:0]      rd_data_o,
  input  logic                   rd_yumi_i,
  output logic                   core_v_o,
  input  logic                   core_ready_i,
  output logic [AES_BLOCK_W-1:0] core_key_o,
  output logic [AES_BLOCK_W-1:0] core_data_o,
  output logic                   core_decrypt_o,
  input  logic                   core_done_i,
  input  logic [AES_BLOCK_W-1:0] core_data_i,
  output logic                   err_o,
  output logic [1:0]             dbg_state_o
);

  aes_state_e             state_q, state_d;
  logic [2:0]             rd_cnt_q, rd_cnt_d;
  logic [AES_BLOCK_W-1:0] result_q, result_d;
  logic                   key_full_q, key_full_d;
  logic                   mode_q, mode_d;
  logic [3:0]             key_cnt, data_cnt;
  logic                   key_wr, data_wr, data_clr;
`ifdef AES_BRIDGE_TIMEOUT_EN
  logic                   err_q, err_d;
  logic [6:0]             wait_cnt_q, wait_cnt_d;
`endif

  // Key words are always welcome in FILL; data words only until eight are held.
  assign wr_ready_o = (state_q == ST_FILL) && (wr_key_i || data_cnt != 4'(BLOCK_WORDS));
  assign key_wr     = wr_v_i && wr_ready_o &&  wr_key_i;
  assign data_wr    = wr_v_i && wr_ready_o && !wr_key_i;

  aes_word_pack #(.SATURATE(1'b0)) u_key_pack (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .clr_i   (1'b0),
    .wr_i    (key_wr),
    .word_i  (wr_data_i),
    .block_o (core_key_o),
    .cnt_o   (key_cnt)
  );

  aes_word_pack #(.SATURATE(1'b1)) u_data_pack (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .clr_i   (data_clr),
    .wr_i    (data_wr),
    .word_i  (wr_data_i),
    .block_o (core_data_o),
    .cnt_o   (data_cnt)
  );

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    result_d   = result_q;
    mode_d     = mode_q;
    data_clr   = 1'b0;
    key_full_d = key_full_q || (key_wr && key_cnt == 4'(BLOCK_WORDS - 1));
`ifdef AES_BRIDGE_TIMEOUT_EN
    err_d      = err_q;
    wait_cnt_d = '0;
`endif
    if (data_wr && data_cnt == 4'(BLOCK_WORDS - 1)) mode_d = mode_i;

    case (state_q)
      ST_FILL: begin
        // Launch condition is judged on the counts as they will be after this
        // edge, so LAUNCH is entered on the same edge that completes the set.
        if (key_full_d &&
            (data_cnt == 4'(BLOCK_WORDS) ||
             (data_wr && data_cnt == 4'(BLOCK_WORDS - 1))))
          state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (core_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done_i) begin
          result_d = core_data_i;
          rd_cnt_d = '0;
          state_d  = ST_DRAIN;
        end
`ifdef AES_BRIDGE_TIMEOUT_EN
        else if (wait_cnt_q == 7'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          data_clr = 1'b1;
          state_d  = ST_FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + 7'd1;
        end
`endif
      end
      ST_DRAIN: begin
        if (rd_yumi_i) begin
          if (rd_cnt_q == 3'(BLOCK_WORDS - 1)) begin
            rd_cnt_d = '0;
            data_clr = 1'b1;
            state_d  = ST_FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FILL;
      rd_cnt_q   <= '0;
      result_q   <= '0;
      key_full_q <= 1'b0;
      mode_q     <= 1'b0;
`ifdef AES_BRIDGE_TIMEOUT_EN
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      result_q   <= result_d;
      key_full_q <= key_full_d;
      mode_q     <= mode_d;
`ifdef AES_BRIDGE_TIMEOUT_EN
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign core_v_o       = (state_q == ST_LAUNCH);
  assign rd_v_o         = (state_q == ST_DRAIN);
  // Selected purely from registered state; rd_yumi_i only moves rd_cnt_q.
  assign rd_data_o      = result_q[word_lsb(rd_cnt_q) +: WORD_W];
  assign core_decrypt_o = mode_q;
  assign dbg_state_o    = state_q;
`ifdef AES_BRIDGE_TIMEOUT_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_aes_word_bridge.sv
// tb_aes_word_bridge
// Self-checking bench for aes_word_bridge: directed FIPS-197 vectors plus
// randomized operations against a word-level reference model and a stand-in
// AES core. Honours AES_BRIDGE_TIMEOUT_EN for the watchdog scenario.
module tb_aes_word_bridge;
  import aes_pkg::*;

  logic         clk_i = 1'b0;
  logic         reset_n;
  logic         wr_v_i, wr_key_i, mode_i;
  logic [15:0]  wr_data_i;
  logic         wr_ready_o, rd_v_o, rd_yumi_i;
  logic [15:0]  rd_data_o;
  logic         core_v_o, core_ready_i, core_decrypt_o, core_done_i, err_o;
  logic [127:0] core_key_o, core_data_o, core_data_i;
  logic [1:0]   dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // Reference model: words as the CPU wrote them, kept at word granularity.
  logic [15:0] m_key[8];
  logic [15:0] m_data[8];
  int          m_key_wp;
  int          m_data_n;
  bit          m_key_full;
  bit          m_fill;
  logic        m_mode;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [15:0] ct_words[8] = '{16'h3925, 16'h841D, 16'h02DC, 16'h09FB,
                               16'hDC11, 16'h8597, 16'h196A, 16'h0B32};
  logic [15:0] pt_words[8] = '{16'h3243, 16'hF6A8, 16'h885A, 16'h308D,
                               16'h3131, 16'h98A2, 16'hE037, 16'h0734};

  aes_word_bridge dut (
    .clk_i          (clk_i),
    .reset_n        (reset_n),
    .wr_v_i         (wr_v_i),
    .wr_key_i       (wr_key_i),
    .wr_data_i      (wr_data_i),
    .mode_i         (mode_i),
    .wr_ready_o     (wr_ready_o),
    .rd_v_o         (rd_v_o),
    .rd_data_o      (rd_data_o),
    .rd_yumi_i      (rd_yumi_i),
    .core_v_o       (core_v_o),
    .core_ready_i   (core_ready_i),
    .core_key_o     (core_key_o),
    .core_data_o    (core_data_o),
    .core_decrypt_o (core_decrypt_o),
    .core_done_i    (core_done_i),
    .core_data_i    (core_data_i),
    .err_o          (err_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- model helpers ----------------
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_key[i]  = '0;
      m_data[i] = '0;
    end
    m_key_wp   = 0;
    m_data_n   = 0;
    m_key_full = 0;
    m_fill     = 1;
    m_mode     = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [127:0] model_key();
    logic [127:0] b = '0;
    for (int i = 0; i < 8; i++) b = (b << 16) | 128'(m_key[i]);
    return b;
  endfunction

  function automatic logic [127:0] model_data();
    logic [127:0] b = '0;
    for (int i = 0; i < 8; i++) b = (b << 16) | 128'(m_data[i]);
    return b;
  endfunction

  // Stand-in core: real AES answers for the FIPS vector, a reversible mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                           input logic dec);
    if (k == FIPS_KEY && d == FIPS_PT && !dec) return FIPS_CT;
    if (k == FIPS_KEY && d == FIPS_CT &&  dec) return FIPS_PT;
    return dec ? (d ^ ~k) : (d ^ k);
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put_word(input logic is_key, input logic [15:0] w, input logic md);
    logic exp_rdy;
    exp_rdy   = m_fill && (is_key || m_data_n < 8);
    wr_v_i    = 1'b1;
    wr_key_i  = is_key;
    wr_data_i = w;
    mode_i    = md;
    #1;
    check_eq(is_key ? "wr_ready_key" : "wr_ready_data", 128'(wr_ready_o), 128'(exp_rdy));
    tick();
    wr_v_i    = 1'b0;
    wr_data_i = 16'($urandom);
    mode_i    = 1'($urandom);
    if (exp_rdy) begin
      if (is_key) begin
        m_key[m_key_wp] = w;
        m_key_wp = (m_key_wp + 1) % 8;
        if (m_key_wp == 0) m_key_full = 1;
      end else begin
        m_data[m_data_n] = w;
        m_data_n++;
        if (m_data_n == 8) m_mode = md;
      end
    end
    if (m_fill && m_data_n == 8 && m_key_full) m_fill = 0;
  endtask

  task automatic write_keys(input logic [127:0] k);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 1));
      put_word(1'b1, 16'(k >> (16 * (7 - i))), 1'b0);
    end
  endtask

  task automatic write_data(input logic [127:0] d, input bit rand_mode, input logic md);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 1));
      put_word(1'b0, 16'(d >> (16 * (7 - i))), rand_mode ? 1'($urandom_range(0, 1)) : md);
    end
  endtask

  task automatic launch_core(input int rdy_dly, input int lat, output logic [127:0] res);
    logic [127:0] ek, ed;
    ek = model_key();
    ed = model_data();
    check_eq("launch_v", 128'(core_v_o), 128'(1));
    check_eq("launch_state", 128'(dbg_state_o), 128'(ST_LAUNCH));
    check_eq("launch_wr_ready", 128'(wr_ready_o), 128'(0));
    check_eq("core_key", core_key_o, ek);
    check_eq("core_data", core_data_o, ed);
    check_eq("core_decrypt", 128'(core_decrypt_o), 128'(m_mode));
    repeat (rdy_dly) begin
      tick();
      check_eq("hold_v", 128'(core_v_o), 128'(1));
      check_eq("hold_key", core_key_o, ek);
      check_eq("hold_data", core_data_o, ed);
      check_eq("hold_decrypt", 128'(core_decrypt_o), 128'(m_mode));
    end
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    check_eq("wait_state", 128'(dbg_state_o), 128'(ST_WAIT));
    check_eq("wait_v", 128'(core_v_o), 128'(0));
    res = core_fn(ek, ed, m_mode);
    idle(lat);
    core_data_i = res;
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    core_data_i = {$urandom, $urandom, $urandom, $urandom};
    check_eq("drain_v", 128'(rd_v_o), 128'(1));
  endtask

  task automatic drain(input int n_reads);
    logic [15:0] expw;
    for (int k = 0; k < n_reads; k++) begin
      idle($urandom_range(0, 2));
      check_eq("rd_v", 128'(rd_v_o), 128'(1));
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check_eq($sformatf("rd_word%0d", k), 128'(rd_data_o), 128'(expw));
      rd_yumi_i = 1'b1;
      tick();
      rd_yumi_i = 1'b0;
    end
  endtask

  task automatic do_op(input bit wr_key, input logic [127:0] key, input logic [127:0] data,
                       input bit rand_mode, input logic md, input int rdy_dly, input int lat,
                       input bit push_model);
    logic [127:0] res;
    if (wr_key) write_keys(key);
    write_data(data, rand_mode, md);
    launch_core(rdy_dly, lat, res);
    if (push_model)
      for (int k = 0; k < 8; k++) exp_q.push_back(16'(res >> (16 * (7 - k))));
    drain(8);
    m_fill   = 1;
    m_data_n = 0;
    check_eq("done_rd_v", 128'(rd_v_o), 128'(0));
    check_eq("done_state", 128'(dbg_state_o), 128'(ST_FILL));
    check_eq("done_wr_ready", 128'(wr_ready_o), 128'(1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    tick();
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] res;
    wr_v_i = 0; wr_key_i = 0; wr_data_i = '0; mode_i = 0;
    rd_yumi_i = 0; core_ready_i = 0; core_done_i = 0; core_data_i = '0;
    reset_n = 1'b0;
    model_reset();
    idle(3);

    // Reset values
    check_eq("rst_state", 128'(dbg_state_o), 128'(ST_FILL));
    check_eq("rst_wr_ready", 128'(wr_ready_o), 128'(1));
    check_eq("rst_core_v", 128'(core_v_o), 128'(0));
    check_eq("rst_rd_v", 128'(rd_v_o), 128'(0));
    check_eq("rst_rd_data", 128'(rd_data_o), 128'(0));
    check_eq("rst_core_key", core_key_o, 128'(0));
    check_eq("rst_core_data", core_data_o, 128'(0));
    check_eq("rst_decrypt", 128'(core_decrypt_o), 128'(0));
    check_eq("rst_err", 128'(err_o), 128'(0));
    reset_n = 1'b1;
    tick();

    // FIPS-197 encrypt, then decrypt with the retained key
    for (int k = 0; k < 8; k++) exp_q.push_back(ct_words[k]);
    do_op(1, FIPS_KEY, FIPS_PT, 0, 1'b0, 0, 3, 0);
    check_eq("fips_enc_key", core_key_o, FIPS_KEY);
    for (int k = 0; k < 8; k++) exp_q.push_back(pt_words[k]);
    do_op(0, FIPS_KEY, FIPS_CT, 0, 1'b1, 0, 1, 0);
    check_eq("fips_dec_key", core_key_o, FIPS_KEY);

    // Data before key: no launch, 9th data refused, then key completes the set
    do_reset();
    write_data({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    idle(2);
    check_eq("nokey_core_v", 128'(core_v_o), 128'(0));
    check_eq("nokey_state", 128'(dbg_state_o), 128'(ST_FILL));
    put_word(1'b0, 16'hBEEF, 1'b1);
    check_eq("nokey_data_kept", core_data_o, model_data());
    write_keys({$urandom, $urandom, $urandom, $urandom});
    launch_core(5, 2, res);
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(res >> (16 * (7 - k))));
    drain(8);
    m_fill = 1; m_data_n = 0;
    check_eq("nokey_done_state", 128'(dbg_state_o), 128'(ST_FILL));

    // Stray core_done_i and rd_yumi_i in FILL are ignored
    core_done_i = 1'b1;
    rd_yumi_i   = 1'b1;
    core_data_i = {$urandom, $urandom, $urandom, $urandom};
    tick();
    core_done_i = 1'b0;
    rd_yumi_i   = 1'b0;
    check_eq("stray_state", 128'(dbg_state_o), 128'(ST_FILL));
    check_eq("stray_rd_v", 128'(rd_v_o), 128'(0));
    do_op(0, '0, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 1, 0, 1);

    // Randomized operations, occasional partial key rewrites (wrapping)
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) put_word(1'b1, 16'($urandom), 1'b0);
      do_op($urandom_range(0, 2) == 0, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0,
            $urandom_range(0, 3), $urandom_range(0, 6), 1);
    end

    // Reset during DRAIN after 3 reads
    write_data({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    launch_core(0, 2, res);
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(res >> (16 * (7 - k))));
    drain(3);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_rd_v", 128'(rd_v_o), 128'(0));
    check_eq("mid_rst_wr_ready", 128'(wr_ready_o), 128'(1));
    check_eq("mid_rst_state", 128'(dbg_state_o), 128'(ST_FILL));
    check_eq("mid_rst_core_key", core_key_o, 128'(0));
    tick();
    reset_n = 1'b1;
    tick();
    model_reset();
    write_data({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    idle(3);
    check_eq("mid_rst_key_full", 128'(core_v_o), 128'(0));
    write_keys({$urandom, $urandom, $urandom, $urandom});
    launch_core(1, 1, res);
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(res >> (16 * (7 - k))));
    drain(8);
    m_fill = 1; m_data_n = 0;

    // Core never answers
    write_data({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    check_eq("to_launch_v", 128'(core_v_o), 128'(1));
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    check_eq("to_wait", 128'(dbg_state_o), 128'(ST_WAIT));
`ifdef AES_BRIDGE_TIMEOUT_EN
    idle(TIMEOUT_CYCLES - 1);
    check_eq("to_pre_state", 128'(dbg_state_o), 128'(ST_WAIT));
    check_eq("to_pre_err", 128'(err_o), 128'(0));
    tick();
    check_eq("to_state", 128'(dbg_state_o), 128'(ST_FILL));
    check_eq("to_err", 128'(err_o), 128'(1));
    check_eq("to_rd_v", 128'(rd_v_o), 128'(0));
    m_fill = 1; m_data_n = 0;
    do_op(0, '0, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 0, 2, 1);
    check_eq("to_err_sticky", 128'(err_o), 128'(1));
    do_reset();
    check_eq("to_err_cleared", 128'(err_o), 128'(0));
`else
    idle(100);
    check_eq("nto_state", 128'(dbg_state_o), 128'(ST_WAIT));
    check_eq("nto_err", 128'(err_o), 128'(0));
    check_eq("nto_rd_v", 128'(rd_v_o), 128'(0));
    do_reset();
    check_eq("nto_rst_state", 128'(dbg_state_o), 128'(ST_FILL));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
